// File: rtl/sample_chunker_pkg.sv
// rtl/sample_chunker_pkg.sv - shared sizing helpers and state type for sample_chunker (option macro: SAMPLE_CHUNKER_LAST_EN)

// Global width macros, normally supplied by global_parameters.svh; these are fallbacks only.
`ifndef INPUT_BITS
`define INPUT_BITS 10
`endif
`ifndef INPUT_BUS_WIDTH
`define INPUT_BUS_WIDTH 4
`endif

package chunker_pkg;

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  // Beats needed to carry one sample; the last beat may be partially filled.
  function automatic int calc_num_beats(input int input_bits, input int bus_width);
    return (input_bits + bus_width - 1) / bus_width;
  endfunction

  // Beat-index width, never narrower than one bit so single-beat builds stay legal.
  function automatic int calc_idx_w(input int num_beats);
    return (num_beats > 1) ? $clog2(num_beats) : 1;
  endfunction

  localparam int NUM_BEATS = calc_num_beats(`INPUT_BITS, `INPUT_BUS_WIDTH);
  localparam int IDX_W     = calc_idx_w(NUM_BEATS);

endpackage

// File: rtl/sample_chunker_if.sv
// rtl/sample_chunker_if.sv - sample-in / beat-out handshake bundle (option macro: SAMPLE_CHUNKER_LAST_EN)

interface sample_chunker_if #(
  parameter int INPUT_BITS = `INPUT_BITS,
  parameter int BUS_WIDTH  = `INPUT_BUS_WIDTH
);
  logic                  smp_vld;
  logic                  smp_rdy;
  logic [INPUT_BITS-1:0] smp;
  logic                  inp_vld;
  logic                  stall;
  logic [BUS_WIDTH-1:0]  inp;
  logic                  busy;
`ifdef SAMPLE_CHUNKER_LAST_EN
  logic                  inp_last;
  logic [15:0]           smp_cnt;
`endif

`ifdef SAMPLE_CHUNKER_LAST_EN
  // master: the chunker itself
  modport master (input smp_vld, smp, stall,
                  output smp_rdy, inp_vld, inp, busy, inp_last, smp_cnt);
  // slave: upstream feeder plus downstream consumer
  modport slave  (output smp_vld, smp, stall,
                  input smp_rdy, inp_vld, inp, busy, inp_last, smp_cnt);
`else
  // master: the chunker itself
  modport master (input smp_vld, smp, stall,
                  output smp_rdy, inp_vld, inp, busy);
  // slave: upstream feeder plus downstream consumer
  modport slave  (output smp_vld, smp, stall,
                  input smp_rdy, inp_vld, inp, busy);
`endif
endinterface

// File: rtl/sample_chunker.sv
// rtl/sample_chunker.sv - splits one flattened sample into zero-padded bus beats (option macro: SAMPLE_CHUNKER_LAST_EN)

module sample_chunker
  import chunker_pkg::*;
#(
  parameter int INPUT_BITS = `INPUT_BITS,
  parameter int BUS_WIDTH  = `INPUT_BUS_WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  sample_chunker_if.master   bus
);

  localparam int NB    = calc_num_beats(INPUT_BITS, BUS_WIDTH);
  localparam int IW    = calc_idx_w(NB);
  localparam int HOLDW = NB * BUS_WIDTH;
  localparam logic [IW-1:0] LAST_IDX = IW'(NB - 1);

  state_t                      r_state;
  logic [NB-1:0][BUS_WIDTH-1:0] r_hold;
  logic [IW-1:0]               r_idx;
  logic                        r_inp_vld;
  logic                        r_busy;

  logic             w_last;
  logic             w_beat_xfer;
  logic             w_smp_rdy;
  logic             w_smp_xfer;
  logic [HOLDW-1:0] w_smp_ext;
  logic [BUS_WIDTH-1:0] w_beat;

  assign w_last      = (r_idx == LAST_IDX);
  assign w_beat_xfer = r_inp_vld && !bus.stall;
  // Ready passes straight through from stall on the last beat so samples chain without a bubble.
  assign w_smp_rdy   = rst && ((r_state == IDLE) || ((r_state == SEND) && w_last && !bus.stall));
  assign w_smp_xfer  = bus.smp_vld && w_smp_rdy;

  // Sample widened to whole beats; unused top bits of the last beat are zero.
  always_comb begin
    w_smp_ext = '0;
    w_smp_ext[INPUT_BITS-1:0] = bus.smp;
  end

  // Current beat selection; a single-beat build needs no index.
  generate
    if (NB == 1) begin : g_one_beat
      assign w_beat = r_hold[0];
    end else begin : g_multi_beat
      assign w_beat = r_hold[r_idx];
    end
  endgenerate

  // Control FSM: latch a sample, walk its beats, reload on the last beat if another is offered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_idx     <= '0;
      r_inp_vld <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_smp_xfer) begin
            r_hold    <= w_smp_ext;
            r_idx     <= '0;
            r_state   <= SEND;
            r_inp_vld <= 1'b1;
            r_busy    <= 1'b1;
          end
        end
        SEND: begin
          if (w_beat_xfer) begin
            if (!w_last) begin
              r_idx <= r_idx + 1'b1;
            end else if (w_smp_xfer) begin
              r_hold <= w_smp_ext;
              r_idx  <= '0;
            end else begin
              r_idx     <= '0;
              r_state   <= IDLE;
              r_inp_vld <= 1'b0;
              r_busy    <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= IDLE;
          r_inp_vld <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.smp_rdy = w_smp_rdy;
  assign bus.inp_vld = r_inp_vld;
  assign bus.inp     = w_beat;
  assign bus.busy    = r_busy;

`ifdef SAMPLE_CHUNKER_LAST_EN
  logic [15:0] r_smp_cnt;

  // Count fully delivered samples; wraps naturally at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_smp_cnt <= '0;
    end else if (w_beat_xfer && w_last) begin
      r_smp_cnt <= r_smp_cnt + 16'd1;
    end
  end

  assign bus.inp_last = r_inp_vld && w_last;
  assign bus.smp_cnt  = r_smp_cnt;
`endif

endmodule

// File: doc/sample_chunker.md
Name: sample_chunker

Overview:
- Upstream feeder for device_interface.
- Accepts one full flattened input sample per handshake and emits it as a sequence of INPUT_BUS_WIDTH-wide beats on the inp/inp_vld/stall interface that device_interface consumes.
- Zero-pads the final partial beat and honours stall back-pressure.
- Supports back-to-back samples with no idle cycle between them.

Parameters:
- INPUT_BITS, default `INPUT_BITS, flattened sample width in bits.
- BUS_WIDTH, default `INPUT_BUS_WIDTH, beat width in bits.
- NUM_BEATS, default (INPUT_BITS+BUS_WIDTH-1)/BUS_WIDTH (derived, not overridden), beats per sample.

Ports:
- clk  in  1  clock; all state is updated on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- smp_vld  in  1  upstream has a sample on smp.
- smp_rdy  out  1  chunker accepts smp this cycle.
- smp  in  INPUT_BITS  flattened sample.
- inp_vld  out  1  beat on inp is valid.
- stall  in  1  device_interface did not take the current beat.
- inp  out  BUS_WIDTH  current beat.
- busy  out  1  a sample is held and not fully sent.

Behaviour:
- Handshakes:
  - Upstream transfer occurs on an edge where smp_vld && smp_rdy.
  - Downstream beat transfer occurs on an edge where inp_vld && !stall.
  - stall is ignored while inp_vld=0.
- Reset (rst=0):
  - State goes to IDLE.
  - inp_vld=0, inp=0, busy=0, beat index=0, hold register=0.
  - smp_rdy is forced 0 while rst=0.
- State machine:
  - IDLE: smp_rdy=1, inp_vld=0. On an upstream transfer, latch {zero pad, smp} into a (NUM_BEATS*BUS_WIDTH)-bit hold register, set idx=0, go to SEND.
  - SEND: inp_vld=1, busy=1, inp = hold[BUS_WIDTH*idx +: BUS_WIDTH].
    - On a beat transfer with idx<NUM_BEATS-1: increment idx.
    - On a beat transfer with idx==NUM_BEATS-1: the sample is done.
  - smp_rdy in SEND = (idx==NUM_BEATS-1) && !stall, a combinational pass-through allowing chaining.
  - On done with a simultaneous upstream transfer: reload the hold register, idx=0, stay in SEND. There is no bubble; beat 0 of the new sample appears on the next cycle.
  - On done without an upstream transfer: go to IDLE.
- Latency: sample accepted on edge t gives beat 0 valid during cycle t+1. An unstalled sample occupies exactly NUM_BEATS cycles.
- Stall behaviour: while stall=1, inp, idx and the hold register stay bit-stable.
- Padding: bits above INPUT_BITS in the last beat are 0.
- NUM_BEATS==1:
  - Every beat is the last beat.
  - smp_rdy in SEND = !stall.
- Reset mid-sample: the held sample and remaining beats are discarded. After release, the block restarts from IDLE.
- smp is sampled only on the transfer edge; upstream may change it freely at other times.

Optional Feature:
- Macro: SAMPLE_CHUNKER_LAST_EN.
- Defined:
  - Adds output inp_last (1 bit) = inp_vld && idx==NUM_BEATS-1.
  - Adds output smp_cnt (16 bits) = count of fully sent samples, incremented on each last-beat transfer, wrapping 16'hFFFF to 0.
  - Both outputs reset to 0.
- Undefined: neither port nor counter exists; the remaining behaviour is identical.

Decomposition:
- Shared package (chunker_pkg):
  - NUM_BEATS computation.
  - Beat-index width constant, IDX_W = $clog2(NUM_BEATS) with a minimum of 1.
  - State enum {IDLE, SEND}.
- Widths come from global_parameters.svh macros.
- No sub-module; a single flat module is natural.

Test Plan (INPUT_BITS=10, BUS_WIDTH=4, NUM_BEATS=3 unless noted):
- Single sample: smp=10'h2A5, no stall. Required: inp = 4'h5, 4'hA, 4'h2 on cycles t+1..t+3 with inp_vld=1, then inp_vld=0 and smp_rdy=1.
- Stall: stall=1 for 2 cycles during beat 1 of 10'h2A5. Required: inp holds 4'hA for 3 cycles, then 4'h2; 5 valid cycles in total.
- Back-to-back: 10'h2A5 then 10'h3FF offered continuously. Required: beats 5,A,2,F,F,3 on consecutive cycles with no bubble; smp_rdy high only alongside the last beat.
- Stall on last beat while a new sample is pending. Required: smp_rdy=0 during stall, and the new sample is accepted on the first unstalled edge.
- Reset mid-sample: rst=0 after beat 0. Required: inp_vld=0 immediately (asynchronous); after release, the next sample starts at beat 0.
- NUM_BEATS=1 (INPUT_BITS=4, BUS_WIDTH=4): 3 samples back-to-back give 1 beat per cycle. With SAMPLE_CHUNKER_LAST_EN, inp_last=1 on each beat and smp_cnt ends at 3.
